// File: rtl/led_pattern_ctrl_pkg.sv
// Shared types and constants for the LED pattern controller: FSM state
// encoding, switch pattern codes and the per-pattern seed values.
package led_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SHIFT  = 3'd1,
      BOUNCE = 3'd2,
      BLINK  = 3'd3,
      FILL   = 3'd4
   } state_t;

   localparam logic [1:0] PAT_SHIFT  = 2'b00;
   localparam logic [1:0] PAT_BOUNCE = 2'b01;
   localparam logic [1:0] PAT_BLINK  = 2'b10;
   localparam logic [1:0] PAT_FILL   = 2'b11;

   localparam logic [3:0] SEED_SHIFT  = 4'b0001;
   localparam logic [3:0] SEED_BOUNCE = 4'b0001;
   localparam logic [3:0] SEED_BLINK  = 4'b1111;
   localparam logic [3:0] SEED_FILL   = 4'b0000;

   function automatic state_t pat_state(input logic [1:0] pat);
      state_t st;
      case (pat)
         PAT_SHIFT:  st = SHIFT;
         PAT_BOUNCE: st = BOUNCE;
         PAT_BLINK:  st = BLINK;
         default:    st = FILL;
      endcase
      return st;
   endfunction

   function automatic logic [3:0] pat_seed(input logic [1:0] pat);
      logic [3:0] seed;
      case (pat)
         PAT_SHIFT:  seed = SEED_SHIFT;
         PAT_BOUNCE: seed = SEED_BOUNCE;
         PAT_BLINK:  seed = SEED_BLINK;
         default:    seed = SEED_FILL;
      endcase
      return seed;
   endfunction

endpackage

// File: rtl/led_pattern_ctrl_sw_debounce.sv
// Two-flop synchronizer plus per-bit debounce counter for the slide switches.
// sw_db is the accepted value including any change committed at the coming edge.
module sw_debounce #(
   parameter int DB_CYCLES = 50_000,
   parameter int WIDTH     = 4
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] sw_db
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [WIDTH-1:0] sync1_reg;
   logic [WIDTH-1:0] sync2_reg;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= sw;
         sync2_reg <= sync1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [CW-1:0] cnt_reg;
         logic [CW-1:0] cnt_next;
         logic          acc_reg;
         logic          acc_next;

         // Any cycle where the synchronized bit agrees with the accepted one restarts the count.
         always_comb begin
            acc_next = acc_reg;
            cnt_next = '0;
            if (sync2_reg[gi] != acc_reg) begin
               if (cnt_reg == CNT_LAST) begin
                  acc_next = sync2_reg[gi];
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end

         always_ff @(posedge clk_in) begin
            if (rst) begin
               cnt_reg <= '0;
               acc_reg <= 1'b0;
            end else begin
               cnt_reg <= cnt_next;
               acc_reg <= acc_next;
            end
         end

         assign sw_db[gi] = acc_next;
      end
   endgenerate

endmodule

// File: rtl/led_pattern_ctrl.sv
// Mode/step controller for the 4-LED shifter: debounced switches select a
// pattern, a tick divider paces the steps, and led/step are registered here.
module led_pattern_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int TICK_DIV  = 500_000,
   parameter int DB_CYCLES = 50_000
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic [3:0] sw,
   output logic [3:0] led,
   output logic       step,
   output logic [2:0] mode
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [3:0] sw_db;

   sw_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .WIDTH     (4)
   ) u_sw_debounce (
      .clk_in (clk_in),
      .rst    (rst),
      .sw     (sw),
      .sw_db  (sw_db)
   );

   logic       run_acc;
   logic       dir_acc;
   logic [1:0] pat_acc;

   assign run_acc = sw_db[0];
   assign dir_acc = sw_db[1];
   assign pat_acc = sw_db[3:2];

   state_t        state_reg, state_next;
   logic [3:0]    led_reg, led_next;
   logic          step_reg, step_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          bdir_reg, bdir_next;       // bounce direction, 1 = right
   logic [1:0]    last_pat_reg, last_pat_next;
   logic          last_vld_reg, last_vld_next;
   logic          tick;
   logic          reload;
   state_t        target;

   assign tick   = (state_reg != IDLE) && (cnt_reg == CNT_LAST);
   assign target = pat_state(pat_acc);

   // Priority: leaving to IDLE, then pattern change/reload, then the tick update.
   always_comb begin
      state_next    = state_reg;
      led_next      = led_reg;
      step_next     = 1'b0;
      cnt_next      = cnt_reg;
      bdir_next     = bdir_reg;
      last_pat_next = last_pat_reg;
      last_vld_next = last_vld_reg;
      reload        = 1'b0;

      if (!run_acc) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else begin
         last_pat_next = pat_acc;
         last_vld_next = 1'b1;
         if (state_reg == IDLE) begin
            state_next = target;
            cnt_next   = '0;
            reload     = !last_vld_reg || (last_pat_reg != pat_acc);
         end else if (state_reg != target) begin
            state_next = target;
            cnt_next   = '0;
            reload     = 1'b1;
         end else if (tick) begin
            cnt_next  = '0;
            step_next = 1'b1;
            case (state_reg)
               SHIFT: begin
                  led_next = dir_acc ? {led_reg[0], led_reg[3:1]}
                                     : {led_reg[2:0], led_reg[3]};
               end
               BOUNCE: begin
                  if (!bdir_reg) begin
                     if (led_reg[3]) begin
                        led_next  = {1'b0, led_reg[3:1]};
                        bdir_next = 1'b1;
                     end else begin
                        led_next = {led_reg[2:0], 1'b0};
                     end
                  end else begin
                     if (led_reg[0]) begin
                        led_next  = {led_reg[2:0], 1'b0};
                        bdir_next = 1'b0;
                     end else begin
                        led_next = {1'b0, led_reg[3:1]};
                     end
                  end
               end
               BLINK: begin
                  led_next = ~led_reg;
               end
               FILL: begin
                  if (led_reg == 4'b1111) begin
                     led_next = 4'b0000;
                  end else begin
                     led_next = dir_acc ? {1'b1, led_reg[3:1]}
                                        : {led_reg[2:0], 1'b1};
                  end
               end
               default: begin
                  led_next = led_reg;
               end
            endcase
         end else begin
            cnt_next = cnt_reg + 1'b1;
         end
      end

      if (reload) begin
         led_next  = pat_seed(pat_acc);
         bdir_next = 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_reg    <= IDLE;
         led_reg      <= 4'b0001;
         step_reg     <= 1'b0;
         cnt_reg      <= '0;
         bdir_reg     <= 1'b0;
         last_pat_reg <= PAT_SHIFT;
         last_vld_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         led_reg      <= led_next;
         step_reg     <= step_next;
         cnt_reg      <= cnt_next;
         bdir_reg     <= bdir_next;
         last_pat_reg <= last_pat_next;
         last_vld_reg <= last_vld_next;
      end
   end

   assign led  = led_reg;
   assign step = step_reg;
   assign mode = state_reg;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with TICK_DIV=4, DB_CYCLES=3;
// expected values are hand-derived cycle by cycle from the switch timeline.
module tb_led_pattern_ctrl;
   import led_ctrl_pkg::*;

   logic       clk_in = 1'b0;
   logic       rst;
   logic [3:0] sw;
   logic [3:0] led;
   logic       step;
   logic [2:0] mode;

   int checks = 0;
   int errors = 0;

   led_pattern_ctrl #(
      .TICK_DIV  (4),
      .DB_CYCLES (3)
   ) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .sw     (sw),
      .led    (led),
      .step   (step),
      .mode   (mode)
   );

   always #5 clk_in = ~clk_in;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      $display("check %-14s led=%b step=%b mode=%0d observed=%b expected=%b",
               tag, led, step, mode, obs, exp);
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] e_led,
                            input logic e_step, input logic [2:0] e_mode);
      check({tag, ".led"},  led,           e_led);
      check({tag, ".step"}, {3'b000, step}, {3'b000, e_step});
      check({tag, ".mode"}, {1'b0, mode},   {1'b0, e_mode});
   endtask

   initial begin
      rst = 1'b1;
      sw  = 4'b0000;
      cyc(2);
      check_all("reset", 4'b0001, 1'b0, IDLE);
      rst = 1'b0;

      // 1: run, rotate left
      sw = 4'b0001;
      cyc(4); check("t1_notyet", {1'b0, mode}, {1'b0, IDLE});
      cyc(1); check_all("t1_enter", 4'b0001, 1'b0, SHIFT);
      cyc(3); check_all("t1_pre", 4'b0001, 1'b0, SHIFT);
      cyc(1); check_all("t1_s1", 4'b0010, 1'b1, SHIFT);
      cyc(1); check("t1_steplow", {3'b000, step}, 4'b0000);
      cyc(3); check("t1_s2", led, 4'b0100);
      cyc(4); check("t1_s3", led, 4'b1000);

      // 2: dir=right, accepted one cycle before the next tick
      cyc(2); sw = 4'b0011;
      cyc(2); check_all("t1_s4", 4'b0001, 1'b1, SHIFT);
      cyc(4); check("t2_r1", led, 4'b1000);
      cyc(4); check("t2_r2", led, 4'b0100);
      sw = 4'b0001;                       // two-cycle glitch on dir
      cyc(2); sw = 4'b0011;
      cyc(2); check("t2_r3", led, 4'b0010);
      cyc(4); check("t2_r4", led, 4'b0001);

      // 3: bounce
      sw = 4'b0101;
      cyc(4); check("t3_lastshift", led, 4'b1000);
      cyc(1); check_all("t3_seed", 4'b0001, 1'b0, BOUNCE);
      cyc(4); check("t3_b1", led, 4'b0010);
      cyc(4); check("t3_b2", led, 4'b0100);
      sw = 4'b0111;                       // dir toggle ignored by bounce
      cyc(4); check("t3_b3", led, 4'b1000);
      cyc(4); check("t3_b4", led, 4'b0100);
      cyc(4); check("t3_b5", led, 4'b0010);
      cyc(4); check("t3_b6", led, 4'b0001);
      cyc(4); check_all("t3_b7", 4'b0010, 1'b1, BOUNCE);

      // 4: blink, then fill accepted on a tick edge
      sw = 4'b1001;
      cyc(5); check_all("t4_blink", 4'b1111, 1'b0, BLINK);
      cyc(4); check_all("t4_k1", 4'b0000, 1'b1, BLINK);
      cyc(3); sw = 4'b1101;
      cyc(1); check("t4_k2", led, 4'b1111);
      cyc(4); check_all("t4_fill", 4'b0000, 1'b0, FILL);
      cyc(4); check_all("t4_f1", 4'b0001, 1'b1, FILL);
      cyc(4); check("t4_f2", led, 4'b0011);
      cyc(4); check("t4_f3", led, 4'b0111);
      cyc(4); check("t4_f4", led, 4'b1111);
      cyc(4); check("t4_f5", led, 4'b0000);

      // 5: pause and resume in SHIFT
      sw = 4'b0001;
      cyc(5); check_all("t5_seed", 4'b0001, 1'b0, SHIFT);
      cyc(4); check("t5_s1", led, 4'b0010);
      cyc(3); sw = 4'b0000;
      cyc(1); check("t5_s2", led, 4'b0100);
      cyc(4); check_all("t5_pause", 4'b0100, 1'b0, IDLE);
      cyc(4); check_all("t5_hold", 4'b0100, 1'b0, IDLE);
      sw = 4'b0001;
      cyc(5); check_all("t5_resume", 4'b0100, 1'b0, SHIFT);
      cyc(3); check_all("t5_wait", 4'b0100, 1'b0, SHIFT);
      cyc(1); check_all("t5_s3", 4'b1000, 1'b1, SHIFT);

      // 6: reset in the middle of a BOUNCE count
      sw = 4'b0101;
      cyc(5); check_all("t6_seed", 4'b0001, 1'b0, BOUNCE);
      cyc(4); check("t6_b1", led, 4'b0010);
      cyc(4); check("t6_b2", led, 4'b0100);
      cyc(4); check("t6_b3", led, 4'b1000);
      cyc(2); rst = 1'b1;
      cyc(1); check_all("t6_rst", 4'b0001, 1'b0, IDLE);
      rst = 1'b0;
      cyc(4); check("t6_relatch", {1'b0, mode}, {1'b0, IDLE});
      cyc(1); check_all("t6_reenter", 4'b0001, 1'b0, BOUNCE);
      cyc(4); check_all("t6_b4", 4'b0010, 1'b1, BOUNCE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Mode and step controller for the 4-LED shifter datapath on the board.
- Synchronizes and debounces the four slide switches.
- Generates the step tick from the 5 MHz domain clock.
- Sequences the LED register through one of four patterns, selected by switches: rotate, ping-pong bounce, blink, bar fill.
- Replaces the free-running divider and shifter pair in the top level; drives the led pins directly.

Parameters:
TICK_DIV, 500_000, clk_in cycles per pattern step (5 MHz -> 10 Hz); legal range >= 2.
DB_CYCLES, 50_000, consecutive stable cycles required before a switch change is accepted (10 ms); legal range >= 1.

Ports:
clk_in  input  1  5 MHz system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
sw  input  4  raw asynchronous slide switches. sw[0]=run, sw[1]=dir (1=right), sw[3:2]=pattern.
led  output  4  LED drive, registered.
step  output  1  one-cycle pulse on each cycle where led advances.
mode  output  3  current FSM state encoding, for debug.

Behaviour:
- Reset (synchronous, active-high, any cycle including mid-step):
  - led=4'b0001, step=0, mode=IDLE.
  - Tick counter=0, debounce counters=0, debounced switches=4'b0000, bounce direction=left.
- Switch input path:
  - 2-FF synchronizer per bit.
  - Per-bit debounce counter: a bit's accepted value changes only after the synchronized value differs from it for DB_CYCLES consecutive cycles; any return to the accepted value clears that bit's counter.
  - Total sw-to-accepted latency = 2 + DB_CYCLES cycles.
- Tick counter:
  - Counts 0..TICK_DIV-1 only while the state is not IDLE; tick is asserted when count==TICK_DIV-1, then the counter wraps to 0.
  - Held at 0 in IDLE.
  - First step after entering a run state comes exactly TICK_DIV cycles later.
- FSM states: IDLE, SHIFT (pat 00), BOUNCE (pat 01), BLINK (pat 10), FILL (pat 11).
  - IDLE -> pattern state when accepted run=1.
  - Any run state -> IDLE when accepted run=0. led holds its value (pause); re-entering the same pattern resumes from the held value, with no reload.
  - Run state -> run state: an accepted pattern change reloads the seed on the next cycle and clears the tick counter.
  - Leaving IDLE into a pattern different from the last run pattern reloads the seed.
- Seeds and per-tick updates:
  - SHIFT, seed 0001: rotate right if dir=1, left if dir=0. Wraps 0001<->1000.
  - BOUNCE, seed 0001 with bounce direction=left, ignores dir: non-rotating shift; reverses at 1000 and at 0001. Sequence 0001,0010,0100,1000,0100,0010,0001,0010...
  - BLINK, seed 1111: toggles 1111<->0000.
  - FILL, seed 0000: if dir=0, led <= {led[2:0],1}; if dir=1, led <= {1,led[3:1]}. From 1111 the next step is 0000.
- A dir change mid-pattern takes effect on the next tick, without reload.
- Simultaneous events:
  - Pattern change coincident with a tick: reload wins, tick discarded, step=0.
  - run falling coincident with a tick: IDLE wins, no update.
  - rst dominates all.
- step is registered alongside led: step=1 in the same cycle the new led value first appears.
- Tick counter width is $clog2(TICK_DIV), with no overflow beyond TICK_DIV-1.

Decomposition:
- Shared package led_ctrl_pkg holds:
  - state enum (IDLE=0, SHIFT=1, BOUNCE=2, BLINK=3, FILL=4);
  - pattern codes PAT_SHIFT/PAT_BOUNCE/PAT_BLINK/PAT_FILL;
  - seed constants SEED_SHIFT=4'b0001, SEED_BOUNCE=4'b0001, SEED_BLINK=4'b1111, SEED_FILL=4'b0000.
- One sub-module, sw_debounce: synchronizer plus per-bit counter, parameter DB_CYCLES, width 4. It is instantiated once.
- Tick counter and FSM live in led_pattern_ctrl.

Test Plan (TICK_DIV=4, DB_CYCLES=3):
1. Reset then sw=0001 held -> led=0001; after 5 cycles accepted; step every 4 cycles; led 0010,0100,1000,0001 (rotate left).
2. sw=0011 (run, right) -> 0001,1000,0100,0010,0001. Glitch sw[1] low for 2 cycles mid-run -> no direction change.
3. sw=0101 (bounce) -> sequence 0001,0010,0100,1000,0100,0010,0001 with reversal at both ends; dir toggling has no effect.
4. sw=1001 (blink) -> 1111,0000,1111. Switch to sw=1101 (fill, left) in the same cycle as a tick -> led=0000, step=0, counter cleared; then 0001,0011,0111,1111,0000.
5. Running SHIFT at led=0100, sw[0]->0 -> led holds 0100, step stays 0, mode=IDLE. sw[0]->1 -> resumes 1000 exactly 4 cycles after acceptance.
6. Assert rst mid-BOUNCE at led=1000 while counting down -> next cycle led=0001, step=0, mode=IDLE, bounce direction reset to left.
